// File: rtl/layer_seq_pkg.sv
// Shared types and defaults for the layer sequencer and its RUN watchdog.
package layer_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        FILL,
        CLEAR,
        RUN,
        DONE,
        ERR
    } seq_state_t;

    localparam int unsigned FILL_CYCLES_DEF = 2;
    localparam int unsigned TIMEOUT_DEF     = 255;
    localparam int unsigned WDOG_MIN_W      = 8;

    // Watchdog counter width: wide enough for TIMEOUT, never narrower than 8 bits.
    function automatic int unsigned wdog_width(input int unsigned timeout);
        int unsigned w;
        w = $clog2(timeout + 1);
        return (w > WDOG_MIN_W) ? w : WDOG_MIN_W;
    endfunction

endpackage

// File: rtl/layer_seq_watchdog.sv
// Counts RUN cycles of the active layer and flags expiry on the TIMEOUT-th cycle.
module layer_seq_watchdog
    import layer_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned   CW    = wdog_width(TIMEOUT);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    // Saturates at LIMIT so a stalled layer cannot wrap back under the threshold.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && (cnt != LIMIT)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = en && (cnt == LIMIT);

endmodule

// File: rtl/layer_sequencer.sv
// Layer-chain sequencer: one-time weight fill, then clear/req/ack each layer in order.
// Optional RUN watchdog and ERR state enabled by defining LAYER_SEQ_WATCHDOG_EN.
module layer_sequencer
    import layer_seq_pkg::*;
#(
    parameter int unsigned N_LAYERS    = 2,
    parameter int unsigned FILL_CYCLES = FILL_CYCLES_DEF,
    parameter int unsigned TIMEOUT     = TIMEOUT_DEF,
    parameter int unsigned LW          = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                fill,
    output logic [N_LAYERS-1:0] layer_rst,
    output logic [N_LAYERS-1:0] layer_req,
    input  logic [N_LAYERS-1:0] layer_ack,
    output logic [LW-1:0]       cur_layer,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int unsigned   FW        = (FILL_CYCLES > 1) ? $clog2(FILL_CYCLES) : 1;
    localparam logic [LW-1:0] LAST_K    = LW'(N_LAYERS - 1);
    localparam logic [FW-1:0] LAST_FILL = FW'(FILL_CYCLES - 1);

    if (N_LAYERS == 0) begin : g_chk_layers
        $error("layer_sequencer: N_LAYERS must be at least 1");
    end
    if (FILL_CYCLES == 0) begin : g_chk_fill
        $error("layer_sequencer: FILL_CYCLES must be at least 1");
    end
    if (TIMEOUT == 0) begin : g_chk_timeout
        $error("layer_sequencer: TIMEOUT must be at least 1");
    end

    seq_state_t          state;
    seq_state_t          next_state;
    logic [LW-1:0]       k;
    logic [LW-1:0]       next_k;
    logic [FW-1:0]       fill_cnt;
    logic [FW-1:0]       next_fill_cnt;
    logic                loaded;
    logic                next_loaded;
    logic                ack_k;
    logic                wd_expired;
    logic [N_LAYERS-1:0] k_onehot;
    logic [N_LAYERS-1:0] layer_rst_q;

    assign ack_k    = layer_ack[k];
    assign k_onehot = N_LAYERS'(1) << next_k;

`ifdef LAYER_SEQ_WATCHDOG_EN
    logic wd_clr;
    logic wd_en;
    logic err_q;

    assign wd_clr = (state == CLEAR);
    assign wd_en  = (state == RUN);

    layer_seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (next_state == ERR);
        end
    end

    assign err = err_q;
`else
    assign wd_expired = 1'b0;
    assign err        = 1'b0;
`endif

    // Next-state logic; ack on the expiry cycle takes priority over the watchdog.
    always_comb begin
        next_state    = state;
        next_k        = k;
        next_fill_cnt = fill_cnt;
        next_loaded   = loaded;
        case (state)
            IDLE: begin
                next_k = '0;
                if (start) begin
                    next_state = loaded ? CLEAR : PRE;
                end
            end
            PRE: begin
                next_state    = FILL;
                next_fill_cnt = '0;
            end
            FILL: begin
                if (fill_cnt == LAST_FILL) begin
                    next_loaded = 1'b1;
                    next_k      = '0;
                    next_state  = CLEAR;
                end else begin
                    next_fill_cnt = fill_cnt + FW'(1);
                end
            end
            CLEAR: begin
                next_state = RUN;
            end
            RUN: begin
                if (ack_k) begin
                    if (k == LAST_K) begin
                        next_state = DONE;
                    end else begin
                        next_k     = k + LW'(1);
                        next_state = CLEAR;
                    end
                end else if (wd_expired) begin
                    next_state = ERR;
                end
            end
            DONE: begin
                next_k     = '0;
                next_state = IDLE;
            end
            ERR: begin
                next_state = ERR;
            end
            default: begin
                next_k     = '0;
                next_state = IDLE;
            end
        endcase
    end

    // State register plus registered output decodes of the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            k           <= '0;
            fill_cnt    <= '0;
            loaded      <= 1'b0;
            fill        <= 1'b0;
            layer_rst_q <= '0;
            layer_req   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= next_state;
            k           <= next_k;
            fill_cnt    <= next_fill_cnt;
            loaded      <= next_loaded;
            fill        <= (next_state == FILL);
            layer_rst_q <= (next_state == PRE)   ? '1 :
                           (next_state == CLEAR) ? k_onehot : '0;
            layer_req   <= (next_state == RUN) ? k_onehot : '0;
            busy        <= (next_state != IDLE);
            done        <= (next_state == DONE);
        end
    end

    // Layers see their counter reset during our own reset cycle as well.
    assign layer_rst = layer_rst_q | {N_LAYERS{rst}};
    assign cur_layer = k;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer with a per-cycle output scoreboard and done-latency queue.
module tb_layer_sequencer;

    localparam int N  = 2;
    localparam int FC = 2;
    localparam int TO = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       fill;
    logic [1:0] layer_rst;
    logic [1:0] layer_req;
    logic [1:0] layer_ack;
    logic [0:0] cur_layer;
    logic       busy;
    logic       done;
    logic       err;

    logic [1:0] model_ack;
    logic [1:0] extra_ack;
    int         req_cnt [2];
    bit         mute;
    int         ack_delay;

    logic [8:0] exp_q [$];
    int         lat_q [$];
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    layer_sequencer #(
        .N_LAYERS    (N),
        .FILL_CYCLES (FC),
        .TIMEOUT     (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .fill      (fill),
        .layer_rst (layer_rst),
        .layer_req (layer_req),
        .layer_ack (layer_ack),
        .cur_layer (cur_layer),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // Layer model: ack on the ack_delay-th cycle of a held req.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            req_cnt[i] <= layer_req[i] ? req_cnt[i] + 1 : 0;
        end
    end

    always @* begin
        model_ack = 2'b00;
        for (int i = 0; i < 2; i++) begin
            model_ack[i] = !mute && layer_req[i] && (req_cnt[i] == ack_delay - 1);
        end
    end

    assign layer_ack = model_ack | extra_ack;

    function automatic logic [8:0] v(input bit f, input logic [1:0] lr, input logic [1:0] lq,
                                     input bit cur, input bit b, input bit d, input bit e);
        return {f, lr, lq, cur, b, d, e};
    endfunction

    function automatic logic [8:0] obs();
        return {fill, layer_rst, layer_req, cur_layer, busy, done, err};
    endfunction

    task automatic chk(input string tag, input logic [8:0] expv);
        logic [8:0] o;
        o = obs();
        n_cmp++;
        assert (o === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b (fill,lrst,lreq,cur,busy,done,err)", tag, o, expv);
        end
    endtask

    task automatic gen_head(input bit first);
        if (first) begin
            exp_q.push_back(v(0, 2'b11, 2'b00, 0, 1, 0, 0));
            for (int i = 0; i < FC; i++) exp_q.push_back(v(1, 2'b00, 2'b00, 0, 1, 0, 0));
        end
    endtask

    task automatic gen_layer(input int k, input int r);
        logic [1:0] oh;
        oh = 2'b01 << k;
        exp_q.push_back(v(0, oh, 2'b00, k[0], 1, 0, 0));
        for (int i = 0; i < r; i++) exp_q.push_back(v(0, 2'b00, oh, k[0], 1, 0, 0));
    endtask

    task automatic gen_tail();
        exp_q.push_back(v(0, 2'b00, 2'b00, 1, 1, 1, 0));
        exp_q.push_back(v(0, 2'b00, 2'b00, 0, 0, 0, 0));
    endtask

    // Steps len cycles after start; optionally injects a stray start and a stray ack[1] during RUN of layer 0.
    task automatic run_seq(input int len, input bit inject);
        int exp_lat;
        for (int i = 1; i <= len; i++) begin
            @(posedge clk); #1;
            start     = inject && (i == 3);
            extra_ack = (inject && i >= 2 && i <= 4) ? 2'b10 : 2'b00;
            n_cmp++;
            assert (exp_q.size() > 0) else begin
                n_bad++;
                $error("FAIL scoreboard_empty: observed cycle %0d expected queued vector", i);
            end
            if (exp_q.size() > 0) chk($sformatf("cycle%0d", i), exp_q.pop_front());
            if (done === 1'b1) begin
                exp_lat = (lat_q.size() > 0) ? lat_q.pop_front() - 1 : -1;
                n_cmp++;
                assert (i === exp_lat) else begin
                    n_bad++;
                    $error("FAIL done_latency: observed done %0d cycles after start, expected %0d", i, exp_lat);
                end
            end
        end
    endtask

    task automatic do_pass(input bit first, input int r, input bit inject);
        gen_head(first);
        gen_layer(0, r);
        gen_layer(1, r);
        gen_tail();
        lat_q.push_back(1 + (first ? 1 + FC : 0) + N * (1 + r) + 1);
        start = 1'b1;
        run_seq(exp_q.size(), inject);
        n_cmp++;
        assert (lat_q.size() === 0) else begin
            n_bad++;
            $error("FAIL done_missing: observed %0d pending, expected 0", lat_q.size());
            lat_q.delete();
        end
    endtask

    task automatic reset_cycle(input string tag);
        rst = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_in_rst"}, v(0, 2'b11, 2'b00, 0, 0, 0, 0));
        rst = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_idle"}, v(0, 2'b00, 2'b00, 0, 0, 0, 0));
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        extra_ack = 2'b00;
        mute      = 1'b0;
        ack_delay = 3;

        reset_cycle("reset");

        // First pass loads weights; second skips PRE/FILL.
        do_pass(1, 3, 0);
        do_pass(0, 3, 0);
        // Stray start and non-current ack during RUN change nothing.
        do_pass(0, 3, 1);

        // Abort during RUN of layer 1.
        gen_head(0);
        gen_layer(0, 3);
        gen_layer(1, 3);
        gen_tail();
        lat_q.push_back(0);
        start = 1'b1;
        run_seq(6, 0);
        exp_q.delete();
        lat_q.delete();
        rst = 1'b1;
        #1;
        n_cmp++;
        assert (layer_rst === 2'b11) else begin
            n_bad++;
            $error("FAIL rst_comb_layer_rst: observed %b expected 11", layer_rst);
        end
        @(posedge clk); #1;
        chk("abort_in_rst", v(0, 2'b11, 2'b00, 0, 0, 0, 0));
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_idle", v(0, 2'b00, 2'b00, 0, 0, 0, 0));
        // loaded was cleared, so PRE/FILL return.
        do_pass(1, 3, 0);

`ifdef LAYER_SEQ_WATCHDOG_EN
        reset_cycle("wd_reset");
        mute = 1'b1;
        gen_head(1);
        gen_layer(0, TO);
        for (int i = 0; i < 3; i++) exp_q.push_back(v(0, 2'b00, 2'b00, 0, 1, 0, 1));
        start = 1'b1;
        run_seq(exp_q.size(), 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("err_ignores_start", v(0, 2'b00, 2'b00, 0, 1, 0, 1));
        @(posedge clk); #1;
        chk("err_sticky", v(0, 2'b00, 2'b00, 0, 1, 0, 1));
        reset_cycle("err_clear");
        mute      = 1'b0;
        ack_delay = TO;
        do_pass(1, TO, 0);
`else
        reset_cycle("stall_reset");
        mute = 1'b1;
        gen_head(1);
        gen_layer(0, 20);
        start = 1'b1;
        run_seq(exp_q.size(), 0);
        reset_cycle("stall_clear");
        mute = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
